mult_datapath: RTL and testbench
================================

# mult_datapath

Operand/accumulator datapath that responds to the multiplier sequencing controller. It holds two WIDTH-bit operands, splits each into HALF-bit halves, and forms one partial product per cycle from the controller's select lines (Asel, Bsel, mult_sel, ans_sel, resultRes). Each product is shifted and accumulated into a 2·WIDTH-bit result register. It sits between the operand source and the controller, and raises a one-cycle done strobe when the final partial product has been accumulated.

## Interface
- WIDTH, 8: operand width; must be even.
- HALF, WIDTH/2: half-operand width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- A_in  in  WIDTH  multiplicand source.
- B_in  in  WIDTH  multiplier source.
- mult_sel  in  1  operand load / hold-result; 1 = load A_in/B_in.
- resultRes  in  1  clear result register.
- Asel  in  1  A half select: 0 = A[HALF-1:0], 1 = A[WIDTH-1:HALF].
- Bsel  in  1  B half select: same encoding as Asel.
- ans_sel  in  2  accumulate shift: 00 = <<0, 01 = <<HALF, 10 = <<WIDTH, 11 = no accumulate.
- result  out  2·WIDTH  accumulator register.
- done  out  1  one-cycle strobe after the ans_sel=10 accumulation.

## Operation
- Registers: opA, opB (WIDTH each), acc (2·WIDTH, drives result), done.
- While rst=0: opA, opB and acc are 0 and done is 0, asynchronously. The first update after rst deasserts happens on the next rising edge.
- Operand load: on each edge with mult_sel=1, opA←A_in and opB←B_in.
  - The controller holds mult_sel=1 throughout idle, so the operands captured are those present on the edge where the controller leaves idle.
- Clear: on an edge with resultRes=1, acc←0. Clear takes priority over accumulation and is independent of the operand load.
- Accumulate enable: acc_en = !mult_sel & !resultRes & (ans_sel≠11).
- Partial product pp = selected half of opA × selected half of opB. pp is WIDTH bits wide and is unsigned.
- On each edge with acc_en=1: acc ← acc + (pp << shift). shift is 0, HALF or WIDTH per ans_sel.
  - The sum is taken modulo 2^(2·WIDTH).
  - A legal four-step sequence never overflows.
- done←1 on each edge with acc_en=1 and ans_sel=10; otherwise done←0.
- acc holds its value whenever acc_en=0 and resultRes=0. In particular, result stays stable through idle until the next clear.
- Controller sequence consumed (state: signals → action):
  - idle: mult_sel=1 → load operands.
  - S1: resultRes=1 → clear acc.
  - S2: Asel=0, Bsel=0, ans_sel=00 → add lo·lo.
  - S3: Asel=0, Bsel=1, ans_sel=01 → add lo·hi<<HALF.
  - S4: Asel=1, Bsel=0, ans_sel=01 → add hi·lo<<HALF.
  - S5: Asel=1, Bsel=1, ans_sel=10 → add hi·hi<<WIDTH, set done.
  - Then return to idle.
- Simultaneous events:
  - mult_sel=1 with resultRes=1: operands load and acc clears on the same edge.
  - mult_sel=1 with any ans_sel: no accumulation.
- Reset mid-operation: acc, opA, opB and done go to 0 immediately. The datapath has no internal state beyond these registers, so the next controller sequence restarts cleanly.

## Timing
- All state is updated on the rising edge of clk.
- Operands are captured at edge E0, the edge where the controller leaves idle.
- Edge by edge after E0:
  - E1: acc clears.
  - E2 to E5: accumulate one partial product each.
- result is final after E5. done is 1 for exactly the cycle between E5 and E6.
- Latency from the capture edge to the final result is 5 cycles.
- Back-to-back operations: a new capture edge can follow E5 directly. result holds its final value until the next S1 clear edge.
- There is no combinational path from inputs to outputs; result and done are register outputs.

## Test plan
- WIDTH=8, A_in=0xB7, B_in=0x5C, full controller sequence:
  - result after E2/E3/E4/E5 = 0x0054 / 0x0284 / 0x0AC4 / 0x41C4.
  - done=1 only after E5.
- Extremes, each as a full sequence:
  - 0xFF×0xFF → 0xFE01.
  - 0x00×0xA5 → 0x0000.
  - 0x01×0x80 → 0x0080.
  - done pulses once per operation.
- Operand change after capture: change A_in to 0x00 during S1–S5 of 0xB7×0x5C.
  - Result is still 0x41C4, because mult_sel=0 blocks the reload.
- Hold and reserved code: after 0x41C4, drive idle for 10 cycles, then drive ans_sel=11 with mult_sel=0 for 3 cycles.
  - result stays 0x41C4.
  - done stays 0.
- Reset mid-operation: assert rst=0 asynchronously during S3.
  - result=0 and done=0 without waiting for a clock edge.
  - A following full 0x12×0x34 sequence gives 0x03A8.
- Back-to-back: 0x0F×0x0F immediately followed by 0xF0×0x0F.
  - 0x00E1, then 0x0E10.
  - Exactly one done per operation.

Source files
------------

// File: rtl/mult_datapath.sv
// mult_datapath: operand/accumulator datapath for a half-width shift-add multiplier.
// Holds two WIDTH-bit operands. Each cycle the controller picks one half of each
// operand. Their product is shifted and added into a 2*WIDTH-bit accumulator.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A_in,
  input  logic [WIDTH-1:0]     B_in,
  input  logic                 mult_sel,
  input  logic                 resultRes,
  input  logic                 Asel,
  input  logic                 Bsel,
  input  logic [1:0]           ans_sel,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;

  logic [HALF-1:0]    w_a_half;
  logic [HALF-1:0]    w_b_half;
  logic [WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0] w_pp_ext;
  logic [2*WIDTH-1:0] w_addend;
  logic               w_acc_en;

  assign w_a_half = Asel ? r_opA[WIDTH-1:HALF] : r_opA[HALF-1:0];
  assign w_b_half = Bsel ? r_opB[WIDTH-1:HALF] : r_opB[HALF-1:0];

  // Both factors are zero-extended to WIDTH bits, so the product is formed unsigned and cannot be truncated.
  assign w_pp     = {{HALF{1'b0}}, w_a_half} * {{HALF{1'b0}}, w_b_half};
  assign w_pp_ext = {{WIDTH{1'b0}}, w_pp};

  // ans_sel=11 is the hold code. A load or a clear also blocks accumulation.
  assign w_acc_en = !mult_sel && !resultRes && (ans_sel != 2'b11);

  // Select the shift amount that aligns the partial product.
  always_comb begin
    w_addend = '0;
    case (ans_sel)
      2'b00:   w_addend = w_pp_ext;
      2'b01:   w_addend = w_pp_ext << HALF;
      2'b10:   w_addend = w_pp_ext << WIDTH;
      default: w_addend = '0;
    endcase
  end

  // Capture the operands while the controller holds mult_sel high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opA <= '0;
      r_opB <= '0;
    end else if (mult_sel) begin
      r_opA <= A_in;
      r_opB <= B_in;
    end
  end

  // Accumulator. A clear has priority over an add. The sum wraps modulo 2^(2*WIDTH).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (resultRes) begin
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= r_acc + w_addend;
    end
  end

  // done is a one-cycle strobe that follows the final hi*hi accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_acc_en && (ans_sel == 2'b10);
    end
  end

  assign result = r_acc;
  assign done   = r_done;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed testbench for mult_datapath (WIDTH=8).
module tb_mult_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A_in = 8'h00;
  logic [7:0]  B_in = 8'h00;
  logic        mult_sel = 1'b1;
  logic        resultRes = 1'b0;
  logic        Asel = 1'b0;
  logic        Bsel = 1'b0;
  logic [1:0]  ans_sel = 2'b00;
  logic [15:0] result;
  logic        done;

  int errors = 0;
  int checks = 0;

  mult_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .A_in(A_in), .B_in(B_in),
    .mult_sel(mult_sel), .resultRes(resultRes), .Asel(Asel), .Bsel(Bsel),
    .ans_sel(ans_sel), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required finish before 200000", $time);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ms, input logic rr, input logic as, input logic bs,
                       input logic [1:0] an);
    mult_sel = ms; resultRes = rr; Asel = as; Bsel = bs; ans_sel = an;
  endtask

  // Runs one full controller sequence from the idle edge E0 through E5.
  // On return the inputs are set to idle, and E6 has not happened yet.
  task automatic do_seq(input logic [7:0] a, input logic [7:0] b, input bit zap_a,
                        output logic [15:0] r2, output logic [15:0] r3,
                        output logic [15:0] r4, output logic [15:0] r5,
                        output logic [5:0] dv);
    A_in = a; B_in = b;
    drive(1, 0, 0, 0, 2'b00); step; dv[0] = done;
    if (zap_a) A_in = 8'h00;
    drive(0, 1, 0, 0, 2'b00); step; dv[1] = done;
    drive(0, 0, 0, 0, 2'b00); step; dv[2] = done; r2 = result;
    drive(0, 0, 0, 1, 2'b01); step; dv[3] = done; r3 = result;
    drive(0, 0, 1, 0, 2'b01); step; dv[4] = done; r4 = result;
    drive(0, 0, 1, 1, 2'b10); step; dv[5] = done; r5 = result;
    drive(1, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset;
    A_in = 8'hAA; B_in = 8'h55;
    drive(1, 0, 0, 0, 2'b00);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 16'h0000); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected %b", done, 1'b0); end
    step;
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_held: got %h expected %h", result, 16'h0000); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] r2, r3, r4, r5;
    logic [5:0]  dv;
    do_seq(8'hB7, 8'h5C, 1'b0, r2, r3, r4, r5, dv);
    checks++;
    if (r2 !== 16'h0054) begin errors++; $display("FAIL basic_E2: got %h expected %h", r2, 16'h0054); end
    checks++;
    if (r3 !== 16'h0284) begin errors++; $display("FAIL basic_E3: got %h expected %h", r3, 16'h0284); end
    checks++;
    if (r4 !== 16'h0AC4) begin errors++; $display("FAIL basic_E4: got %h expected %h", r4, 16'h0AC4); end
    checks++;
    if (r5 !== 16'h41C4) begin errors++; $display("FAIL basic_E5: got %h expected %h", r5, 16'h41C4); end
    checks++;
    if (dv !== 6'b100000) begin errors++; $display("FAIL basic_done_pattern: got %b expected %b", dv, 6'b100000); end
    step;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_E6: got %b expected %b", done, 1'b0); end
  endtask

  task automatic test_extremes;
    logic [7:0]  ta [3] = '{8'hFF, 8'h00, 8'h01};
    logic [7:0]  tb [3] = '{8'hFF, 8'hA5, 8'h80};
    logic [15:0] te [3] = '{16'hFE01, 16'h0000, 16'h0080};
    logic [15:0] r2, r3, r4, r5;
    logic [5:0]  dv;
    for (int i = 0; i < 3; i++) begin
      do_seq(ta[i], tb[i], 1'b0, r2, r3, r4, r5, dv);
      checks++;
      if (r5 !== te[i]) begin errors++; $display("FAIL extreme_%0d_result: got %h expected %h", i, r5, te[i]); end
      checks++;
      if (dv !== 6'b100000) begin errors++; $display("FAIL extreme_%0d_done: got %b expected %b", i, dv, 6'b100000); end
    end
    step;
  endtask

  task automatic test_operand_change;
    logic [15:0] r2, r3, r4, r5;
    logic [5:0]  dv;
    do_seq(8'hB7, 8'h5C, 1'b1, r2, r3, r4, r5, dv);
    checks++;
    if (r5 !== 16'h41C4) begin errors++; $display("FAIL operand_change: got %h expected %h", r5, 16'h41C4); end
  endtask

  task automatic test_hold;
    logic bad_r, bad_d;
    bad_r = 1'b0; bad_d = 1'b0;
    A_in = 8'h33; B_in = 8'h77;
    drive(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step;
      if (result !== 16'h41C4) bad_r = 1'b1;
      if (done !== 1'b0) bad_d = 1'b1;
    end
    checks++;
    if (bad_r) begin errors++; $display("FAIL hold_idle_result: got %h expected %h", result, 16'h41C4); end
    checks++;
    if (bad_d) begin errors++; $display("FAIL hold_idle_done: got 1 expected 0"); end
    bad_r = 1'b0; bad_d = 1'b0;
    drive(0, 0, 1, 1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step;
      if (result !== 16'h41C4) bad_r = 1'b1;
      if (done !== 1'b0) bad_d = 1'b1;
    end
    checks++;
    if (bad_r) begin errors++; $display("FAIL hold_code11_result: got %h expected %h", result, 16'h41C4); end
    checks++;
    if (bad_d) begin errors++; $display("FAIL hold_code11_done: got 1 expected 0"); end
    drive(1, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset_mid;
    logic [15:0] r2, r3, r4, r5;
    logic [5:0]  dv;
    A_in = 8'hB7; B_in = 8'h5C;
    drive(1, 0, 0, 0, 2'b00); step;
    drive(0, 1, 0, 0, 2'b00); step;
    drive(0, 0, 0, 0, 2'b00); step;
    checks++;
    if (result !== 16'h0054) begin errors++; $display("FAIL mid_pre_reset: got %h expected %h", result, 16'h0054); end
    drive(0, 0, 0, 1, 2'b01);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL mid_reset_result: got %h expected %h", result, 16'h0000); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected %b", done, 1'b0); end
    @(negedge clk);
    rst = 1'b1;
    do_seq(8'h12, 8'h34, 1'b0, r2, r3, r4, r5, dv);
    checks++;
    if (r5 !== 16'h03A8) begin errors++; $display("FAIL mid_after_reset: got %h expected %h", r5, 16'h03A8); end
    checks++;
    if (dv !== 6'b100000) begin errors++; $display("FAIL mid_after_done: got %b expected %b", dv, 6'b100000); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r2, r3, r4, r5;
    logic [5:0]  dv;
    step;
    do_seq(8'h0F, 8'h0F, 1'b0, r2, r3, r4, r5, dv);
    checks++;
    if (r5 !== 16'h00E1) begin errors++; $display("FAIL b2b_first: got %h expected %h", r5, 16'h00E1); end
    checks++;
    if (dv !== 6'b100000) begin errors++; $display("FAIL b2b_first_done: got %b expected %b", dv, 6'b100000); end
    do_seq(8'hF0, 8'h0F, 1'b0, r2, r3, r4, r5, dv);
    checks++;
    if (r5 !== 16'h0E10) begin errors++; $display("FAIL b2b_second: got %h expected %h", r5, 16'h0E10); end
    checks++;
    if (dv !== 6'b100000) begin errors++; $display("FAIL b2b_second_done: got %b expected %b", dv, 6'b100000); end
    step;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end: got %b expected %b", done, 1'b0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_operand_change;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
